// File: rtl/gpio_intr_prio_if.sv
// Bus bundle between the GPIO interrupt priority controller and the CPU side.
// slave = controller, master = source/CPU driver.
interface gpio_intr_prio_if #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 2
);
    localparam int unsigned ID_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] src_en;
    logic               cfg_wr;
    logic [ID_W-1:0]    cfg_idx;
    logic [PRIO_W-1:0]  cfg_prio;
    logic               intr_req;
    logic [ID_W-1:0]    intr_id;
    logic               intr_ack;
    logic               intr_done;
    logic [NUM_SRC-1:0] pending;
    logic               in_service;
    logic [PRIO_W-1:0]  cur_prio;

    modport slave (
        input  src_in, src_en, cfg_wr, cfg_idx, cfg_prio, intr_ack, intr_done,
        output intr_req, intr_id, pending, in_service, cur_prio
    );

    modport master (
        output src_in, src_en, cfg_wr, cfg_idx, cfg_prio, intr_ack, intr_done,
        input  intr_req, intr_id, pending, in_service, cur_prio
    );
endinterface

// File: rtl/gpio_intr_prio_ctrl.sv
// GPIO port-A interrupt priority controller: edge capture, priority arbitration, CPU request/service tracking.
// Optional nested preemption with a save stack when INTR_PRIO_PREEMPT_EN is defined.
module gpio_intr_prio_ctrl #(
    parameter int unsigned NUM_SRC    = 8,
    parameter int unsigned PRIO_W     = 2,
    parameter int unsigned NEST_DEPTH = 2
) (
    input  logic            pclk,
    input  logic            prst,
    gpio_intr_prio_if.slave bus
);
    localparam int unsigned ID_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [NUM_SRC-1:0]              sync1_q, sync2_q, sync3_q;
    logic [2:0]                      vld_q;
    logic [NUM_SRC-1:0]              pending_q, pending_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0]  prio_q, prio_d;
    logic                            intr_req_q, intr_req_d;
    logic [ID_W-1:0]                 intr_id_q, intr_id_d;
    logic                            in_service_q, in_service_d;
    logic [PRIO_W-1:0]               cur_prio_q, cur_prio_d;

    logic [NUM_SRC-1:0]              edge_c;
    logic [NUM_SRC-1:0]              clr_c;
    logic                            win_vld_c;
    logic [ID_W-1:0]                 win_id_c;
    logic [PRIO_W-1:0]               win_prio_c;

`ifdef INTR_PRIO_PREEMPT_EN
    localparam int unsigned SP_W = $clog2(NEST_DEPTH + 1);

    logic [ID_W-1:0]                     cur_id_q, cur_id_d;
    logic [SP_W-1:0]                     sp_q, sp_d;
    logic [NEST_DEPTH-1:0][PRIO_W-1:0]   stk_prio_q, stk_prio_d;
    logic [NEST_DEPTH-1:0][ID_W-1:0]     stk_id_q, stk_id_d;
`else
    if (NEST_DEPTH == 0) begin : g_no_nest
    end
`endif

    // vld_q masks edges until sync3_q holds a real post-reset sample, so a level
    // already high at reset release is not seen as a rise.
    assign edge_c = sync2_q & ~sync3_q & {NUM_SRC{vld_q[2]}};

    // Highest priority wins; strict compare keeps the lowest index on ties and drops prio 0.
    always_comb begin
        win_vld_c  = 1'b0;
        win_id_c   = '0;
        win_prio_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pending_q[i] && bus.src_en[i] && (prio_q[i] > win_prio_c)) begin
                win_vld_c  = 1'b1;
                win_id_c   = ID_W'(i);
                win_prio_c = prio_q[i];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        intr_id_d    = intr_id_q;
        in_service_d = in_service_q;
        cur_prio_d   = cur_prio_q;
        prio_d       = prio_q;
        clr_c        = '0;
`ifdef INTR_PRIO_PREEMPT_EN
        cur_id_d     = cur_id_q;
        sp_d         = sp_q;
        stk_prio_d   = stk_prio_q;
        stk_id_d     = stk_id_q;
`endif

        if (bus.cfg_wr && (32'(bus.cfg_idx) < NUM_SRC)) begin
            prio_d[bus.cfg_idx] = bus.cfg_prio;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (win_vld_c) begin
                    state_d   = ST_REQ;
                    intr_id_d = win_id_c;
                end
            end
            ST_REQ: begin
                if (bus.intr_ack) begin
                    clr_c[intr_id_q] = 1'b1;
                    cur_prio_d       = prio_q[intr_id_q];
                    in_service_d     = 1'b1;
                    state_d          = ST_SERVICE;
`ifdef INTR_PRIO_PREEMPT_EN
                    cur_id_d = intr_id_q;
                    if (in_service_q) begin
                        for (int unsigned j = 0; j < NEST_DEPTH; j++) begin
                            if (32'(sp_q) == j) begin
                                stk_prio_d[j] = cur_prio_q;
                                stk_id_d[j]   = cur_id_q;
                            end
                        end
                        sp_d = sp_q + SP_W'(1);
                    end
`endif
                end
            end
            ST_SERVICE: begin
                if (bus.intr_done) begin
`ifdef INTR_PRIO_PREEMPT_EN
                    if (sp_q != '0) begin
                        for (int unsigned j = 0; j < NEST_DEPTH; j++) begin
                            if (32'(sp_q) == j + 1) begin
                                cur_prio_d = stk_prio_q[j];
                                cur_id_d   = stk_id_q[j];
                            end
                        end
                        sp_d = sp_q - SP_W'(1);
                    end else begin
                        cur_prio_d   = '0;
                        in_service_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
`else
                    cur_prio_d   = '0;
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
`endif
                end
`ifdef INTR_PRIO_PREEMPT_EN
                else if (win_vld_c && (win_prio_c > cur_prio_q) && (32'(sp_q) < NEST_DEPTH)) begin
                    state_d   = ST_REQ;
                    intr_id_d = win_id_c;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new edge in the same cycle as the ack clear keeps the bit set.
        pending_d  = (pending_q & ~clr_c) | edge_c;
        intr_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= ST_IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            vld_q        <= '0;
            pending_q    <= '0;
            prio_q       <= '0;
            intr_req_q   <= 1'b0;
            intr_id_q    <= '0;
            in_service_q <= 1'b0;
            cur_prio_q   <= '0;
`ifdef INTR_PRIO_PREEMPT_EN
            cur_id_q     <= '0;
            sp_q         <= '0;
            stk_prio_q   <= '0;
            stk_id_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= bus.src_in;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            vld_q        <= {vld_q[1:0], 1'b1};
            pending_q    <= pending_d;
            prio_q       <= prio_d;
            intr_req_q   <= intr_req_d;
            intr_id_q    <= intr_id_d;
            in_service_q <= in_service_d;
            cur_prio_q   <= cur_prio_d;
`ifdef INTR_PRIO_PREEMPT_EN
            cur_id_q     <= cur_id_d;
            sp_q         <= sp_d;
            stk_prio_q   <= stk_prio_d;
            stk_id_q     <= stk_id_d;
`endif
        end
    end

    assign bus.intr_req   = intr_req_q;
    assign bus.intr_id    = intr_id_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
    assign bus.cur_prio   = cur_prio_q;
endmodule

// File: tb/tb_gpio_intr_prio_ctrl.sv
// Self-checking bench for gpio_intr_prio_ctrl: directed scenarios plus randomized
// batches checked against a priority-order reference model.
module tb_gpio_intr_prio_ctrl;
    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned PRIO_W  = 2;
    localparam int unsigned ID_W    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpio_intr_prio_if #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) bus ();

    gpio_intr_prio_ctrl #(
        .NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .NEST_DEPTH(2)
    ) dut (
        .pclk(clk),
        .prst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int unsigned m_prio [NUM_SRC];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.src_in    = '0;
        bus.src_en    = '0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_prio  = '0;
        bus.intr_ack  = 1'b0;
        bus.intr_done = 1'b0;
        step(3);
        rst = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) m_prio[i] = 0;
    endtask

    task automatic set_prio(input int idx, input int unsigned p);
        bus.cfg_wr   = 1'b1;
        bus.cfg_idx  = ID_W'(idx);
        bus.cfg_prio = PRIO_W'(p);
        step();
        bus.cfg_wr   = 1'b0;
        m_prio[idx]  = p;
    endtask

    task automatic pulse_ack();
        bus.intr_ack = 1'b1;
        step();
        bus.intr_ack = 1'b0;
    endtask

    task automatic pulse_done();
        bus.intr_done = 1'b1;
        step();
        bus.intr_done = 1'b0;
    endtask

    task automatic wait_req(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (bus.intr_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Reference: scan priority levels from highest down, first enabled pending index wins.
    function automatic int exp_winner(input logic [NUM_SRC-1:0] pend, input logic [NUM_SRC-1:0] en);
        for (int p = (1 << PRIO_W) - 1; p >= 1; p--)
            for (int i = 0; i < int'(NUM_SRC); i++)
                if (pend[i] && en[i] && m_prio[i] == p) return i;
        return -1;
    endfunction

    task automatic test_reset();
        bit quiet;
        rst = 1'b1;
        bus.src_in = 8'hFF;
        bus.src_en = 8'hFF;
        bus.cfg_wr = 1'b0;
        bus.intr_ack = 1'b0;
        bus.intr_done = 1'b0;
        step(3);
        n_cmp++;
        if ({bus.intr_req, bus.intr_id, bus.pending, bus.in_service, bus.cur_prio} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: observed req=%0b id=%0d pend=%0h insvc=%0b prio=%0d required all 0",
                     bus.intr_req, bus.intr_id, bus.pending, bus.in_service, bus.cur_prio);
        end
        rst = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) set_prio(i, 3);
        quiet = 1'b1;
        repeat (10) begin
            step();
            if (bus.intr_req !== 1'b0 || bus.pending !== 8'h00) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_edge: observed req=%0b pend=%0h required req=0 pend=0", bus.intr_req, bus.pending);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_prio(0, 1);
        bus.src_en = 8'h01;
        bus.src_in[0] = 1'b1;
        step(3);
        n_cmp++;
        if (bus.pending !== 8'h01 || bus.intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pend_k2: observed pend=%0h req=%0b required pend=01 req=0", bus.pending, bus.intr_req);
        end
        step();
        n_cmp++;
        if (bus.intr_req !== 1'b1 || bus.intr_id !== 3'd0) begin
            n_fail++;
            $display("FAIL single_req_k3: observed req=%0b id=%0d required req=1 id=0", bus.intr_req, bus.intr_id);
        end
        pulse_ack();
        n_cmp++;
        if (bus.pending !== 8'h00 || bus.cur_prio !== 2'd1 || bus.in_service !== 1'b1 || bus.intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: observed pend=%0h prio=%0d insvc=%0b req=%0b required 0/1/1/0",
                     bus.pending, bus.cur_prio, bus.in_service, bus.intr_req);
        end
        pulse_done();
        n_cmp++;
        if (bus.in_service !== 1'b0 || bus.cur_prio !== 2'd0) begin
            n_fail++;
            $display("FAIL single_done: observed insvc=%0b prio=%0d required 0/0", bus.in_service, bus.cur_prio);
        end
    endtask

    task automatic test_priority();
        int exp_ids [3] = '{2, 0, 1};
        bit ok;
        do_reset();
        set_prio(0, 2);
        set_prio(1, 2);
        set_prio(2, 3);
        bus.src_en = 8'hFF;
        bus.src_in = 8'h07;
        step(4);
        for (int k = 0; k < 3; k++) begin
            wait_req(8, ok);
            n_cmp++;
            if (!ok || bus.intr_id !== ID_W'(exp_ids[k])) begin
                n_fail++;
                $display("FAIL prio_order[%0d]: observed req=%0b id=%0d required id=%0d", k, ok, bus.intr_id, exp_ids[k]);
            end
            pulse_ack();
            pulse_done();
        end
        n_cmp++;
        if (bus.pending !== 8'h00) begin
            n_fail++;
            $display("FAIL prio_drained: observed pend=%0h required 00", bus.pending);
        end
    endtask

    task automatic test_nesting();
        bit ok;
        do_reset();
        set_prio(0, 1);
        set_prio(1, 2);
        bus.src_en = 8'h03;
        bus.src_in[0] = 1'b1;
        wait_req(10, ok);
        n_cmp++;
        if (!ok || bus.intr_id !== 3'd0) begin
            n_fail++;
            $display("FAIL nest_first_req: observed req=%0b id=%0d required id=0", ok, bus.intr_id);
        end
        pulse_ack();
        step(65);
        bus.src_in[1] = 1'b1;
`ifdef INTR_PRIO_PREEMPT_EN
        step(4);
        n_cmp++;
        if (bus.intr_req !== 1'b1 || bus.intr_id !== 3'd1 || bus.cur_prio !== 2'd1) begin
            n_fail++;
            $display("FAIL nest_preempt_req: observed req=%0b id=%0d prio=%0d required 1/1/1", bus.intr_req, bus.intr_id, bus.cur_prio);
        end
        pulse_ack();
        n_cmp++;
        if (bus.cur_prio !== 2'd2 || bus.in_service !== 1'b1) begin
            n_fail++;
            $display("FAIL nest_ack: observed prio=%0d insvc=%0b required 2/1", bus.cur_prio, bus.in_service);
        end
        pulse_done();
        n_cmp++;
        if (bus.cur_prio !== 2'd1 || bus.in_service !== 1'b1 || bus.intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL nest_pop: observed prio=%0d insvc=%0b req=%0b required 1/1/0", bus.cur_prio, bus.in_service, bus.intr_req);
        end
        pulse_done();
        n_cmp++;
        if (bus.cur_prio !== 2'd0 || bus.in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL nest_idle: observed prio=%0d insvc=%0b required 0/0", bus.cur_prio, bus.in_service);
        end
`else
        ok = 1'b1;
        repeat (8) begin
            step();
            if (bus.intr_req !== 1'b0) ok = 1'b0;
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL nest_no_preempt: observed req=%0b id=%0d required req=0", bus.intr_req, bus.intr_id);
        end
        pulse_done();
        n_cmp++;
        if (bus.intr_req !== 1'b0 || bus.in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL nest_done: observed req=%0b insvc=%0b required 0/0", bus.intr_req, bus.in_service);
        end
        step();
        n_cmp++;
        if (bus.intr_req !== 1'b1 || bus.intr_id !== 3'd1) begin
            n_fail++;
            $display("FAIL nest_rearb: observed req=%0b id=%0d required 1/1", bus.intr_req, bus.intr_id);
        end
        pulse_ack();
        pulse_done();
`endif
    endtask

    task automatic test_set_clear();
        bit ok;
        do_reset();
        set_prio(3, 1);
        bus.src_en = 8'hFF;
        bus.src_in[3] = 1'b1;
        wait_req(10, ok);
        n_cmp++;
        if (!ok || bus.intr_id !== 3'd3) begin
            n_fail++;
            $display("FAIL setclr_req: observed req=%0b id=%0d required id=3", ok, bus.intr_id);
        end
        bus.src_in[3] = 1'b0;
        step(3);
        bus.src_in[3] = 1'b1;
        step(2);
        pulse_ack();
        n_cmp++;
        if (bus.pending !== 8'h08 || bus.in_service !== 1'b1) begin
            n_fail++;
            $display("FAIL setclr_keep: observed pend=%0h insvc=%0b required 08/1", bus.pending, bus.in_service);
        end
        pulse_done();
        wait_req(4, ok);
        n_cmp++;
        if (!ok || bus.intr_id !== 3'd3) begin
            n_fail++;
            $display("FAIL setclr_rereq: observed req=%0b id=%0d required id=3", ok, bus.intr_id);
        end
        pulse_ack();
        pulse_done();
    endtask

    task automatic test_mask();
        bit quiet;
        do_reset();
        set_prio(4, 1);
        bus.src_en = 8'hEF;
        bus.src_in[4] = 1'b1;
        step(4);
        quiet = (bus.intr_req === 1'b0);
        repeat (5) begin
            step();
            if (bus.intr_req !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (bus.pending !== 8'h10 || quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_hold: observed pend=%0h req=%0b required 10/0", bus.pending, bus.intr_req);
        end
        bus.src_en = 8'hFF;
        step();
        n_cmp++;
        if (bus.intr_req !== 1'b1 || bus.intr_id !== 3'd4) begin
            n_fail++;
            $display("FAIL mask_release: observed req=%0b id=%0d required 1/4", bus.intr_req, bus.intr_id);
        end
        pulse_ack();
        pulse_done();
    endtask

    task automatic test_midreset();
        bit ok;
        do_reset();
        set_prio(5, 2);
        bus.src_en = 8'hFF;
        bus.src_in[5] = 1'b1;
        wait_req(10, ok);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(8);
        n_cmp++;
        if (!ok || bus.intr_req !== 1'b0 || bus.pending !== 8'h00 || bus.in_service !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: observed seen=%0b req=%0b pend=%0h insvc=%0b required 1/0/00/0",
                     ok, bus.intr_req, bus.pending, bus.in_service);
        end
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0] pend;
        logic [NUM_SRC-1:0] en;
        bit ok;
        int w;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            for (int i = 0; i < int'(NUM_SRC); i++) set_prio(i, $urandom_range(0, 3));
            en   = NUM_SRC'($urandom);
            pend = NUM_SRC'($urandom);
            bus.src_en = en;
            bus.src_in = pend;
            step(4);
            n_cmp++;
            if (bus.pending !== pend) begin
                n_fail++;
                $display("FAIL rnd_pend[%0d]: observed %0h required %0h", it, bus.pending, pend);
            end
            for (int k = 0; k < int'(NUM_SRC); k++) begin
                w = exp_winner(pend, en);
                if (w < 0) break;
                wait_req(8, ok);
                n_cmp++;
                if (!ok || bus.intr_id !== ID_W'(w)) begin
                    n_fail++;
                    $display("FAIL rnd_id[%0d.%0d]: observed req=%0b id=%0d required id=%0d", it, k, ok, bus.intr_id, w);
                end
                pulse_ack();
                pend[w] = 1'b0;
                n_cmp++;
                if (bus.cur_prio !== PRIO_W'(m_prio[w]) || bus.pending !== pend) begin
                    n_fail++;
                    $display("FAIL rnd_ack[%0d.%0d]: observed prio=%0d pend=%0h required prio=%0d pend=%0h",
                             it, k, bus.cur_prio, bus.pending, m_prio[w], pend);
                end
                pulse_done();
            end
            ok = 1'b1;
            repeat (6) begin
                step();
                if (bus.intr_req !== 1'b0) ok = 1'b0;
            end
            n_cmp++;
            if (ok !== 1'b1 || bus.pending !== pend) begin
                n_fail++;
                $display("FAIL rnd_tail[%0d]: observed req=%0b pend=%0h required req=0 pend=%0h", it, bus.intr_req, bus.pending, pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_set_clear();
        test_mask();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
